// File: rtl/mac_pipeline_pkg.sv
// Shared definitions for the multiply-accumulate pipeline and its output buffer.
package mac_pipeline_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int PIPE_LATENCY  = 4;

    typedef logic [DEFAULT_WIDTH-1:0] result_t;

endpackage

// File: rtl/pipeline_output_buffer_if.sv
// Valid/ready result stream leaving the output buffer.
interface pipeline_output_buffer_if
    import mac_pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/pipeline_output_buffer_fifo_fwft.sv
// First-word-fall-through FIFO with explicit pointer wrap, so DEPTH need not be a power of two.
module fifo_fwft
    import mac_pipeline_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // Guard here too so a misbehaving caller can never overrun or underrun the storage.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_output_buffer.sv
// Buffers MAC pipeline results, stalls the pipeline when full and counts delivered results.
module pipeline_output_buffer
    import mac_pipeline_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int DEPTH     = 8,
    parameter  int CNT_WIDTH = 32,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i_pipe_out,
    input  logic                 i_pipe_valid,
    output logic                 o_pipe_en,
    pipeline_output_buffer_if.master m_if,
    output logic [OCC_W-1:0]     o_count,
    output logic [CNT_WIDTH-1:0] o_results_delivered
);

    logic [WIDTH-1:0]     w_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_WIDTH-1:0] r_delivered;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Enable depends only on registered occupancy, never on m_ready.
    assign o_pipe_en = !w_full;
    assign w_push    = i_pipe_valid && o_pipe_en;
    assign w_pop     = m_if.m_valid && m_if.m_ready;

    fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (i_pipe_out),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_if.m_data  = w_rdata;
    assign m_if.m_valid = !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delivered <= '0;
        end else if (w_pop) begin
            r_delivered <= sat_inc(r_delivered);
        end
    end

    assign o_results_delivered = r_delivered;

endmodule

// File: tb/tb_pipeline_output_buffer.sv
// Scoreboard bench for pipeline_output_buffer at DEPTH=8 and DEPTH=5.
module tb_pipeline_output_buffer;
    import mac_pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_t     p8_out = '0;
    logic        p8_valid = 1'b0;
    logic        en8;
    logic [3:0]  cnt8;
    logic [31:0] dlv8;

    result_t     p5_out = '0;
    logic        p5_valid = 1'b0;
    logic        en5;
    logic [2:0]  cnt5;
    logic [31:0] dlv5;

    pipeline_output_buffer_if #(.WIDTH(16)) if8 ();
    pipeline_output_buffer_if #(.WIDTH(16)) if5 ();

    pipeline_output_buffer #(.WIDTH(16), .DEPTH(8), .CNT_WIDTH(32)) u_dut8 (
        .clk                 (clk),
        .rst                 (rst),
        .i_pipe_out          (p8_out),
        .i_pipe_valid        (p8_valid),
        .o_pipe_en           (en8),
        .m_if                (if8),
        .o_count             (cnt8),
        .o_results_delivered (dlv8)
    );

    pipeline_output_buffer #(.WIDTH(16), .DEPTH(5), .CNT_WIDTH(32)) u_dut5 (
        .clk                 (clk),
        .rst                 (rst),
        .i_pipe_out          (p5_out),
        .i_pipe_valid        (p5_valid),
        .o_pipe_en           (en5),
        .m_if                (if5),
        .o_count             (cnt5),
        .o_results_delivered (dlv5)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference models: queue contents and delivered count, updated from stimulus only.
    result_t     q8[$];
    result_t     q5[$];
    int unsigned d8 = 0;
    int unsigned d5 = 0;

    always @(posedge rst) begin
        q8.delete();
        q5.delete();
        d8 = 0;
        d5 = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit en_e;
            en_e = (q8.size() != 8);
            chk("count8", 64'(cnt8), 64'(q8.size()));
            chk("valid8", 64'(if8.m_valid), 64'(q8.size() != 0));
            chk("en8", 64'(en8), 64'(en_e));
            chk("dlv8", 64'(dlv8), 64'(d8));
            if (q8.size() != 0 && if8.m_ready) begin
                chk("data8", 64'(if8.m_data), 64'(q8[0]));
                void'(q8.pop_front());
                d8++;
            end
            if (p8_valid && en_e) q8.push_back(p8_out);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit en_e;
            en_e = (q5.size() != 5);
            chk("count5", 64'(cnt5), 64'(q5.size()));
            chk("valid5", 64'(if5.m_valid), 64'(q5.size() != 0));
            chk("en5", 64'(en5), 64'(en_e));
            chk("dlv5", 64'(dlv5), 64'(d5));
            if (q5.size() != 0 && if5.m_ready) begin
                chk("data5", 64'(if5.m_data), 64'(q5[0]));
                void'(q5.pop_front());
                d5++;
            end
            if (p5_valid && en_e) q5.push_back(p5_out);
        end
    end

    initial begin
        if8.m_ready = 1'b0;
        if5.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 64'(cnt8), 64'd0);
        chk("rst_valid", 64'(if8.m_valid), 64'd0);
        chk("rst_en", 64'(en8), 64'd1);
        chk("rst_dlv", 64'(dlv8), 64'd0);

        // Single result
        p8_out = 16'd100;
        p8_valid = 1'b1;
        tick();
        p8_valid = 1'b0;
        if8.m_ready = 1'b1;
        chk("single_valid", 64'(if8.m_valid), 64'd1);
        chk("single_data", 64'(if8.m_data), 64'd100);
        tick();
        chk("single_dlv", 64'(dlv8), 64'd1);
        chk("single_count", 64'(cnt8), 64'd0);

        // Streaming
        for (int i = 1; i <= 20; i++) begin
            p8_out = 16'(i);
            p8_valid = 1'b1;
            tick();
            chk("stream_en", 64'(en8), 64'd1);
            chk("stream_count_le1", 64'(cnt8 <= 4'd1), 64'd1);
        end
        p8_valid = 1'b0;
        tick();
        chk("stream_dlv", 64'(dlv8), 64'd21);

        // Asynchronous reset with three results held
        if8.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p8_out = 16'(200 + i);
            p8_valid = 1'b1;
            tick();
        end
        p8_valid = 1'b0;
        chk("pre_rst_count", 64'(cnt8), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(cnt8), 64'd0);
        chk("arst_valid", 64'(if8.m_valid), 64'd0);
        chk("arst_en", 64'(en8), 64'd1);
        chk("arst_dlv", 64'(dlv8), 64'd0);
        tick();
        rst = 1'b0;

        // Fill to full, then backpressured capture of 18
        for (int i = 0; i < 8; i++) begin
            p8_out = 16'(10 + i);
            p8_valid = 1'b1;
            tick();
        end
        p8_out = 16'd18;
        chk("full_count", 64'(cnt8), 64'd8);
        chk("full_en", 64'(en8), 64'd0);
        tick();
        tick();
        chk("full_hold", 64'(cnt8), 64'd8);
        if8.m_ready = 1'b1;
        tick();
        if8.m_ready = 1'b0;
        chk("freed_en", 64'(en8), 64'd1);
        chk("freed_count", 64'(cnt8), 64'd7);
        tick();
        p8_valid = 1'b0;
        chk("refill_count", 64'(cnt8), 64'd8);
        tick();
        chk("once_count", 64'(cnt8), 64'd8);
        if8.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        if8.m_ready = 1'b0;
        chk("drain_count", 64'(cnt8), 64'd0);
        chk("drain_dlv", 64'(dlv8), 64'd9);

        // Simultaneous push and pop at occupancy 2
        for (int i = 0; i < 2; i++) begin
            p8_out = 16'(50 + i);
            p8_valid = 1'b1;
            tick();
        end
        p8_out = 16'd52;
        if8.m_ready = 1'b1;
        chk("simul_head0", 64'(if8.m_data), 64'd50);
        tick();
        p8_valid = 1'b0;
        chk("simul_count", 64'(cnt8), 64'd2);
        chk("simul_head1", 64'(if8.m_data), 64'd51);
        tick();
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("empty_count", 64'(cnt8), 64'd0);
        chk("empty_valid", 64'(if8.m_valid), 64'd0);
        chk("empty_dlv", 64'(dlv8), 64'd12);
        if8.m_ready = 1'b0;

        // Wrap-around on the non-power-of-two instance
        for (int r = 0; r < 6; r++) begin
            if5.m_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                p5_out = 16'(r * 3 + k);
                p5_valid = 1'b1;
                tick();
            end
            p5_valid = 1'b0;
            chk("wrap_burst_count", 64'(cnt5), 64'd3);
            if5.m_ready = 1'b1;
            for (int k = 0; k < 3; k++) tick();
        end
        if5.m_ready = 1'b0;
        chk("wrap_count", 64'(cnt5), 64'd0);
        chk("wrap_dlv", 64'(dlv5), 64'd18);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
